// File: rtl/keypad_scan_ctrl_if.sv
// rtl/keypad_scan_ctrl_if.sv - keypad matrix pins and key report bundle
interface keypad_scan_ctrl_if;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  col,
        output row,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output col,
        input  row,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad row scanner with press/release debounce
module keypad_scan_ctrl #(
    parameter int TICK_DIV       = 1000000,
    parameter int DEBOUNCE_SCANS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    keypad_scan_ctrl_if.master         kp
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int CW = (DEBOUNCE_SCANS < 2) ? 1 : $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [3:0]     col_q1, col_s;
    logic [TW-1:0]  tick_cnt;
    logic           tick;
    logic [1:0]     row_idx, row_idx_n;
    logic [3:0]     pat, pat_n;
    logic [1:0]     col_idx, col_idx_n;
    logic [CW-1:0]  deb_cnt, deb_cnt_n, deb_inc;
    logic [CW-1:0]  rel_cnt, rel_cnt_n, rel_inc;
    logic [3:0]     key_code, key_code_n;
    logic           key_valid, key_valid_n;
    logic           key_held, key_held_n;
    logic [1:0]     low_idx;

    // Lowest-index low column wins when several keys share the driven row.
    function automatic logic [1:0] lowest_low(input logic [3:0] c);
        if (!c[0])      return 2'd0;
        else if (!c[1]) return 2'd1;
        else if (!c[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q1 <= 4'hF;
            col_s  <= 4'hF;
        end else begin
            col_q1 <= kp.col;
            col_s  <= col_q1;
        end
    end

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SCAN;
            row_idx   <= 2'd0;
            pat       <= 4'hF;
            col_idx   <= 2'd0;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            row_idx   <= row_idx_n;
            pat       <= pat_n;
            col_idx   <= col_idx_n;
            deb_cnt   <= deb_cnt_n;
            rel_cnt   <= rel_cnt_n;
            key_code  <= key_code_n;
            key_valid <= key_valid_n;
            key_held  <= key_held_n;
        end
    end

    assign low_idx = lowest_low(col_s);
    assign deb_inc = deb_cnt + CW'(1);
    assign rel_inc = rel_cnt + CW'(1);

    // Decisions are taken only on tick cycles; key_valid falls on the next
    // cycle because tick cannot repeat back to back.
    always_comb begin
        state_n     = state;
        row_idx_n   = row_idx;
        pat_n       = pat;
        col_idx_n   = col_idx;
        deb_cnt_n   = deb_cnt;
        rel_cnt_n   = rel_cnt;
        key_code_n  = key_code;
        key_valid_n = 1'b0;
        key_held_n  = key_held;

        if (tick) begin
            case (state)
                SCAN: begin
                    if (col_s == 4'hF) begin
                        row_idx_n = row_idx + 2'd1;
                    end else begin
                        pat_n     = col_s;
                        col_idx_n = low_idx;
                        deb_cnt_n = CW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            key_code_n  = {row_idx, low_idx};
                            key_valid_n = 1'b1;
                            key_held_n  = 1'b1;
                            rel_cnt_n   = '0;
                            state_n     = HELD;
                        end else begin
                            state_n = DEBOUNCE;
                        end
                    end
                end

                DEBOUNCE: begin
                    if (col_s == pat) begin
                        deb_cnt_n = deb_inc;
                        if (deb_inc == CW'(DEBOUNCE_SCANS)) begin
                            key_code_n  = {row_idx, col_idx};
                            key_valid_n = 1'b1;
                            key_held_n  = 1'b1;
                            rel_cnt_n   = '0;
                            state_n     = HELD;
                        end
                    end else begin
                        state_n   = SCAN;
                        row_idx_n = row_idx + 2'd1;
                    end
                end

                HELD: begin
                    // Pattern changes within the held row are deliberately ignored.
                    if (col_s == 4'hF) begin
                        rel_cnt_n = rel_inc;
                        if (rel_inc == CW'(DEBOUNCE_SCANS)) begin
                            key_held_n = 1'b0;
                            state_n    = SCAN;
                            row_idx_n  = row_idx + 2'd1;
                        end
                    end else begin
                        rel_cnt_n = '0;
                    end
                end

                default: begin
                    state_n = SCAN;
                end
            endcase
        end
    end

    assign kp.row       = ~(4'b0001 << row_idx);
    assign kp.key_code  = key_code;
    assign kp.key_valid = key_valid;
    assign kp.key_held  = key_held;

endmodule
